// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/game-over sequencing with a three-step
// per-frame update (paddles, ball motion, collision/scoring).
module pong_game_ctrl #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_XL    = 16,
  parameter int PADDLE_XR    = 616,
  parameter int BALL_SZ      = 8,
  parameter int BALL_SPD     = 2,
  parameter int PAD_SPD      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       btn_lu,
  input  logic       btn_ld,
  input  logic       btn_ru,
  input  logic       btn_rd,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_ly,
  output logic [9:0] pad_ry,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] state,
  output logic       busy
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  localparam logic [9:0] BALL_CX    = 10'(H_RES / 2 - BALL_SZ / 2);
  localparam logic [9:0] BALL_CY    = 10'(V_RES / 2 - BALL_SZ / 2);
  localparam logic [9:0] BALL_XMAX  = 10'(H_RES - BALL_SZ);
  localparam logic [9:0] BALL_YMAX  = 10'(V_RES - BALL_SZ);
  localparam logic [9:0] PAD_YMAX   = 10'(V_RES - PADDLE_H);
  localparam logic [9:0] PAD_Y0     = 10'((V_RES - PADDLE_H) / 2);
  localparam logic [9:0] PAD_STEP   = 10'(PAD_SPD);
  localparam logic [9:0] LEFT_FACE  = 10'(PADDLE_XL + PADDLE_W);
  localparam logic [9:0] RIGHT_STOP = 10'(PADDLE_XR - BALL_SZ);

  localparam logic [10:0] XL_W     = 11'(PADDLE_XL);
  localparam logic [10:0] XR_W     = 11'(PADDLE_XR);
  localparam logic [10:0] XR_END_W = 11'(PADDLE_XR + PADDLE_W);
  localparam logic [10:0] PH_W     = 11'(PADDLE_H);
  localparam logic [10:0] BSZ_W    = 11'(BALL_SZ);

  localparam logic signed [10:0] BALL_STEP = 11'(BALL_SPD);
  localparam logic [3:0]         WIN_V     = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LD  = CNT_W'(SERVE_FRAMES);

  typedef enum logic [1:0] {IDLE = 2'b00, SERVE = 2'b01, PLAY = 2'b10, OVER = 2'b11} game_e;
  typedef enum logic [1:0] {STEP_NONE, STEP_PAD, STEP_BALL, STEP_HIT} step_e;

  function automatic logic [9:0] pad_move(input logic [9:0] y, input logic up, input logic dn);
    if (up && !dn) return (y < PAD_STEP) ? '0 : y - PAD_STEP;
    if (dn && !up) return (y > PAD_YMAX - PAD_STEP) ? PAD_YMAX : y + PAD_STEP;
    return y;
  endfunction

  // Signed 11-bit step so a move past either edge clamps instead of wrapping.
  function automatic logic [9:0] axis_step(input logic [9:0] pos, input logic neg,
                                           input logic [9:0] max);
    logic signed [10:0] sum;
    sum = $signed({1'b0, pos}) + (neg ? -BALL_STEP : BALL_STEP);
    if (sum[10]) return '0;
    if (sum > $signed({1'b0, max})) return max;
    return sum[9:0];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN_V) ? WIN_V : s + 4'd1;
  endfunction

  game_e            game_q, game_d;
  step_e            step_q, step_d;
  logic [CNT_W-1:0] serve_cnt;
  logic             dx_neg, dy_neg, start_q;

  logic        start_rise, serve_done;
  logic [10:0] ball_x_end, ball_y_end;
  logic        y_over_l, y_over_r, hit_l, hit_r, miss, miss_left, win;
  logic [3:0]  score_l_inc, score_r_inc;

  assign start_rise = start && !start_q;
  assign serve_done = frame_tick && (serve_cnt <= CNT_W'(1));

  assign ball_x_end = {1'b0, ball_x} + BSZ_W;
  assign ball_y_end = {1'b0, ball_y} + BSZ_W;
  assign y_over_l   = (ball_y_end > {1'b0, pad_ly}) && ({1'b0, ball_y} < {1'b0, pad_ly} + PH_W);
  assign y_over_r   = (ball_y_end > {1'b0, pad_ry}) && ({1'b0, ball_y} < {1'b0, pad_ry} + PH_W);
  assign hit_l      = dx_neg && (ball_x <= LEFT_FACE) && (ball_x_end > XL_W) && y_over_l;
  assign hit_r      = !dx_neg && (ball_x_end >= XR_W) && ({1'b0, ball_x} < XR_END_W) && y_over_r;
  assign miss_left  = (ball_x == '0);
  assign miss       = !hit_l && !hit_r && (miss_left || ball_x == BALL_XMAX);

  assign score_l_inc = sat_inc(score_l);
  assign score_r_inc = sat_inc(score_r);
  assign win         = miss_left ? (score_r_inc == WIN_V) : (score_l_inc == WIN_V);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      game_q <= IDLE;
      step_q <= STEP_NONE;
    end else begin
      game_q <= game_d;
      step_q <= step_d;
    end
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    game_d = game_q;
    step_d = step_q;
    case (game_q)
      IDLE:  if (start) game_d = SERVE;
      SERVE: if (serve_done) game_d = PLAY;
      PLAY: begin
        case (step_q)
          STEP_NONE: if (frame_tick) step_d = STEP_PAD;
          STEP_PAD:  step_d = STEP_BALL;
          STEP_BALL: step_d = STEP_HIT;
          default: begin
            step_d = STEP_NONE;
            if (miss) game_d = win ? OVER : SERVE;
          end
        endcase
      end
      default: if (start_rise) game_d = SERVE;
    endcase
  end

  // Output logic.
  always_comb begin
    state = game_q;
    busy  = (step_q != STEP_NONE);
  end

  // Datapath: positions, directions, scores and serve countdown.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; later assignments in the block take priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      ball_x    <= BALL_CX;
      ball_y    <= BALL_CY;
      pad_ly    <= PAD_Y0;
      pad_ry    <= PAD_Y0;
      score_l   <= '0;
      score_r   <= '0;
      dx_neg    <= 1'b0;
      dy_neg    <= 1'b0;
      serve_cnt <= '0;
      start_q   <= 1'b0;
    end else begin
      start_q <= start;
      case (game_q)
        IDLE: begin
          if (start) begin
            serve_cnt <= SERVE_LD;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
          end
        end
        SERVE: begin
          if (frame_tick) begin
            serve_cnt <= serve_cnt - 1'b1;
            pad_ly    <= pad_move(pad_ly, btn_lu, btn_ld);
            pad_ry    <= pad_move(pad_ry, btn_ru, btn_rd);
          end
        end
        PLAY: begin
          case (step_q)
            STEP_PAD: begin
              pad_ly <= pad_move(pad_ly, btn_lu, btn_ld);
              pad_ry <= pad_move(pad_ry, btn_ru, btn_rd);
            end
            STEP_BALL: begin
              ball_x <= axis_step(ball_x, dx_neg, BALL_XMAX);
              ball_y <= axis_step(ball_y, dy_neg, BALL_YMAX);
            end
            STEP_HIT: begin
              if (ball_y == '0) dy_neg <= 1'b0;
              else if (ball_y == BALL_YMAX) dy_neg <= 1'b1;
              if (hit_l) begin
                ball_x <= LEFT_FACE;
                dx_neg <= 1'b0;
              end else if (hit_r) begin
                ball_x <= RIGHT_STOP;
                dx_neg <= 1'b1;
              end else if (miss) begin
                if (miss_left) score_r <= score_r_inc;
                else           score_l <= score_l_inc;
                dx_neg <= miss_left;
                dy_neg <= 1'b0;
                if (!win) begin
                  ball_x    <= BALL_CX;
                  ball_y    <= BALL_CY;
                  serve_cnt <= SERVE_LD;
                end
              end
            end
            default: ;
          endcase
        end
        default: begin
          if (start_rise) begin
            score_l   <= '0;
            score_r   <= '0;
            ball_x    <= BALL_CX;
            ball_y    <= BALL_CY;
            serve_cnt <= SERVE_LD;
          end
        end
      endcase
    end
  end

endmodule
